// File: rtl/mips_ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and
// load-use / forwarding hazard detection for the decode stage.
module mips_ex_stage (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        stallE,
  input  logic        ALUflush,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [4:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [31:0] SignImmE,
  input  logic [31:0] uSignImmE,
  input  logic [4:0]  shmntE,
  input  logic [31:0] PCE,
  input  logic [31:0] jumpaddM,
  input  logic [4:0]  NextRs,
  input  logic [4:0]  NextRt,
  input  logic [5:0]  Nextop,
  input  logic        forwardArs,
  input  logic        forwardArt,
  input  logic [31:0] ALUOutEf,
  input  logic        forwardBrs,
  input  logic        forwardBrt,
  input  logic [31:0] MemDataEf,
  input  logic        forwardCrs,
  input  logic        forwardCrt,
  input  logic [31:0] MforwardE,
  output logic        RWE,
  output logic        MRE,
  output logic        MWE,
  output logic        BranchE,
  output logic [31:0] ALUOutE,
  output logic [31:0] WriteDataE,
  output logic [4:0]  WriteRegE,
  output logic [31:0] targetaddE,
  output logic        hazardArs,
  output logic        hazardArt,
  output logic        hazardBrs,
  output logic        hazardBrt,
  output logic        stallsigE
);

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpAddu  = 5'd1;
  localparam logic [4:0] OpSub   = 5'd2;
  localparam logic [4:0] OpSubu  = 5'd3;
  localparam logic [4:0] OpAnd   = 5'd4;
  localparam logic [4:0] OpOr    = 5'd5;
  localparam logic [4:0] OpXor   = 5'd6;
  localparam logic [4:0] OpNor   = 5'd7;
  localparam logic [4:0] OpSlt   = 5'd8;
  localparam logic [4:0] OpSll   = 5'd9;
  localparam logic [4:0] OpSrl   = 5'd10;
  localparam logic [4:0] OpSra   = 5'd11;
  localparam logic [4:0] OpSllv  = 5'd12;
  localparam logic [4:0] OpSrlv  = 5'd13;
  localparam logic [4:0] OpSrav  = 5'd14;
  localparam logic [4:0] OpAddi  = 5'd15;
  localparam logic [4:0] OpAddiu = 5'd16;
  localparam logic [4:0] OpAndi  = 5'd17;
  localparam logic [4:0] OpOri   = 5'd18;
  localparam logic [4:0] OpXori  = 5'd19;
  localparam logic [4:0] OpLw    = 5'd20;
  localparam logic [4:0] OpSw    = 5'd21;
  localparam logic [4:0] OpBeq   = 5'd22;
  localparam logic [4:0] OpBne   = 5'd23;
  localparam logic [4:0] OpJ     = 5'd24;
  localparam logic [4:0] OpJal   = 5'd25;
  localparam logic [4:0] OpJr    = 5'd26;

  logic [31:0] opA, opR, opB;
  logic [31:0] result, target;
  logic        taken;
  logic [4:0]  dest;
  logic        rsCmp, rtCmp, hzValid;
  logic        matchRs, matchRt;

  assign opA = forwardArs ? ALUOutEf :
               forwardBrs ? MemDataEf :
               forwardCrs ? MforwardE : SrcAE;
  assign opR = forwardArt ? ALUOutEf :
               forwardBrt ? MemDataEf :
               forwardCrt ? MforwardE : SrcBE;
  assign opB = ALUSrcE ? SignImmE : opR;

  always_comb begin
    result = 32'd0;
    target = 32'd0;
    taken  = 1'b0;
    case (ALUControlE)
      OpAdd, OpAddu:   result = opA + opB;
      OpSub, OpSubu:   result = opA - opB;
      OpAnd:           result = opA & opB;
      OpOr:            result = opA | opB;
      OpXor:           result = opA ^ opB;
      OpNor:           result = ~(opA | opB);
      OpSlt:           result = {31'd0, $signed(opA) < $signed(opB)};
      OpSll:           result = opR << shmntE;
      OpSrl:           result = opR >> shmntE;
      OpSra:           result = $signed(opR) >>> shmntE;
      OpSllv:          result = opR << opA[4:0];
      OpSrlv:          result = opR >> opA[4:0];
      OpSrav:          result = $signed(opR) >>> opA[4:0];
      OpAddi, OpAddiu: result = opA + SignImmE;
      OpAndi:          result = opA & uSignImmE;
      OpOri:           result = opA | uSignImmE;
      OpXori:          result = opA ^ uSignImmE;
      OpLw, OpSw:      result = opA + SignImmE;
      OpBeq: begin
        taken  = (opA == opR);
        target = PCE + 32'd1 + SignImmE;
      end
      OpBne: begin
        taken  = (opA != opR);
        target = PCE + 32'd1 + SignImmE;
      end
      OpJ: begin
        taken  = 1'b1;
        target = jumpaddM;
      end
      OpJal: begin
        taken  = 1'b1;
        target = jumpaddM;
        result = PCE + 32'd1;
      end
      OpJr: begin
        taken  = 1'b1;
        target = opA;
      end
      default: result = 32'd0;
    endcase
  end

  assign dest = (ALUControlE == OpJal) ? 5'd31 :
                RegDstE ? RdE : RtE;

  // Only I-type rt is a source for R-type, beq/bne and sw
  assign rsCmp   = !(Nextop == 6'd2 || Nextop == 6'd3);
  assign rtCmp   = (Nextop == 6'd0) || (Nextop == 6'd4) ||
                   (Nextop == 6'd5) || (Nextop == 6'h2B);
  assign hzValid = RegWriteE && (dest != 5'd0);
  assign matchRs = hzValid && rsCmp && (NextRs == dest);
  assign matchRt = hzValid && rtCmp && (NextRt == dest);

  always_ff @(posedge CLOCK) begin
    if (RESET || ALUflush) begin
      RWE        <= 1'b0;
      MRE        <= 1'b0;
      MWE        <= 1'b0;
      BranchE    <= 1'b0;
      ALUOutE    <= 32'd0;
      WriteDataE <= 32'd0;
      WriteRegE  <= 5'd0;
      targetaddE <= 32'd0;
      hazardArs  <= 1'b0;
      hazardArt  <= 1'b0;
      hazardBrs  <= 1'b0;
      hazardBrt  <= 1'b0;
      stallsigE  <= 1'b0;
    end else if (stallE) begin
      // Bubble; hazard flags hold for the stalled consumer
      RWE        <= 1'b0;
      MRE        <= 1'b0;
      MWE        <= 1'b0;
      BranchE    <= 1'b0;
      ALUOutE    <= 32'd0;
      WriteDataE <= 32'd0;
      WriteRegE  <= 5'd0;
      targetaddE <= 32'd0;
      stallsigE  <= 1'b0;
    end else begin
      RWE        <= RegWriteE;
      MRE        <= MemtoRegE;
      MWE        <= MemWriteE;
      BranchE    <= taken;
      ALUOutE    <= result;
      WriteDataE <= opR;
      WriteRegE  <= dest;
      targetaddE <= target;
      hazardArs  <= matchRs && !MemtoRegE;
      hazardArt  <= matchRt && !MemtoRegE;
      hazardBrs  <= matchRs && MemtoRegE;
      hazardBrt  <= matchRt && MemtoRegE;
      stallsigE  <= (matchRs || matchRt) && MemtoRegE;
    end
  end

endmodule

// File: tb/tb_mips_ex_stage.sv
// Directed testbench for mips_ex_stage.
module tb_mips_ex_stage;

  logic        CLOCK = 1'b0;
  logic        RESET, stallE, ALUflush;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [4:0]  ALUControlE;
  logic        ALUSrcE, RegDstE;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RtE, RdE;
  logic [31:0] SignImmE, uSignImmE;
  logic [4:0]  shmntE;
  logic [31:0] PCE, jumpaddM;
  logic [4:0]  NextRs, NextRt;
  logic [5:0]  Nextop;
  logic        forwardArs, forwardArt, forwardBrs, forwardBrt;
  logic        forwardCrs, forwardCrt;
  logic [31:0] ALUOutEf, MemDataEf, MforwardE;
  logic        RWE, MRE, MWE, BranchE;
  logic [31:0] ALUOutE, WriteDataE, targetaddE;
  logic [4:0]  WriteRegE;
  logic        hazardArs, hazardArt, hazardBrs, hazardBrt;
  logic        stallsigE;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  mips_ex_stage dut (
    .CLOCK(CLOCK), .RESET(RESET), .stallE(stallE),
    .ALUflush(ALUflush), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RegDstE(RegDstE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .uSignImmE(uSignImmE), .shmntE(shmntE), .PCE(PCE),
    .jumpaddM(jumpaddM), .NextRs(NextRs), .NextRt(NextRt),
    .Nextop(Nextop), .forwardArs(forwardArs),
    .forwardArt(forwardArt), .ALUOutEf(ALUOutEf),
    .forwardBrs(forwardBrs), .forwardBrt(forwardBrt),
    .MemDataEf(MemDataEf), .forwardCrs(forwardCrs),
    .forwardCrt(forwardCrt), .MforwardE(MforwardE),
    .RWE(RWE), .MRE(MRE), .MWE(MWE), .BranchE(BranchE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .targetaddE(targetaddE),
    .hazardArs(hazardArs), .hazardArt(hazardArt),
    .hazardBrs(hazardBrs), .hazardBrt(hazardBrt),
    .stallsigE(stallsigE)
  );

  task automatic clr();
    RESET = 0; stallE = 0; ALUflush = 0;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    ALUControlE = 5'd27; ALUSrcE = 0; RegDstE = 0;
    SrcAE = 0; SrcBE = 0; RtE = 0; RdE = 0;
    SignImmE = 0; uSignImmE = 0; shmntE = 0;
    PCE = 0; jumpaddM = 0;
    NextRs = 0; NextRt = 0; Nextop = 6'h3F;
    forwardArs = 0; forwardArt = 0;
    forwardBrs = 0; forwardBrt = 0;
    forwardCrs = 0; forwardCrt = 0;
    ALUOutEf = 0; MemDataEf = 0; MforwardE = 0;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    clr();
    RESET = 1;
    step();
    checks++;
    if (ALUOutE !== 32'd0 || RWE !== 1'b0 || stallsigE !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: alu=%h rwe=%b stall=%b required 0",
               ALUOutE, RWE, stallsigE);
    end
    // load with a dependent: reset must still win
    clr();
    RESET = 1; ALUControlE = 5'd20; SrcAE = 10; SignImmE = 4;
    RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1; RtE = 8;
    NextRs = 8; Nextop = 6'd0; ALUflush = 0;
    step();
    checks++;
    if ({RWE, MRE, MWE, BranchE, hazardArs, hazardArt,
         hazardBrs, hazardBrt, stallsigE} !== 9'd0 ||
        ALUOutE !== 0 || WriteDataE !== 0 ||
        WriteRegE !== 0 || targetaddE !== 0) begin
      errors++;
      $display("FAIL reset_prio: alu=%h wr=%0d stall=%b hBrs=%b required 0",
               ALUOutE, WriteRegE, stallsigE, hazardBrs);
    end
  endtask

  task automatic test_add_forward();
    clr();
    ALUControlE = 5'd0; SrcAE = 5; SrcBE = 7; RegDstE = 1; RdE = 3;
    RegWriteE = 1; NextRs = 3; NextRt = 9; Nextop = 6'd0;
    step();
    checks++;
    if (ALUOutE !== 32'd12 || WriteRegE !== 5'd3 || RWE !== 1'b1) begin
      errors++;
      $display("FAIL add_basic: alu=%0d wr=%0d rwe=%b required 12 3 1",
               ALUOutE, WriteRegE, RWE);
    end
    checks++;
    if ({hazardArs, hazardArt, hazardBrs, stallsigE} !== 4'b1000) begin
      errors++;
      $display("FAIL add_hazard: flags=%b required 1000",
               {hazardArs, hazardArt, hazardBrs, stallsigE});
    end
    clr();
    ALUControlE = 5'd0; forwardArs = 1; ALUOutEf = 12; SrcAE = 99;
    SrcBE = 1; RegDstE = 1; RdE = 4; RegWriteE = 1;
    NextRs = 7; Nextop = 6'd0;
    step();
    checks++;
    if (ALUOutE !== 32'd13 || hazardArs !== 1'b0) begin
      errors++;
      $display("FAIL add_fwd: alu=%0d hArs=%b required 13 0",
               ALUOutE, hazardArs);
    end
  endtask

  task automatic test_load_stall();
    clr();
    ALUControlE = 5'd20; SrcAE = 10; SignImmE = 4; MemtoRegE = 1;
    RegWriteE = 1; RtE = 8; NextRs = 8; Nextop = 6'd0;
    step();
    checks++;
    if (ALUOutE !== 32'd14 || stallsigE !== 1'b1 || hazardBrs !== 1'b1 ||
        hazardArs !== 1'b0 || MRE !== 1'b1 || WriteRegE !== 5'd8) begin
      errors++;
      $display("FAIL lw_issue: alu=%0d stall=%b hBrs=%b hArs=%b mre=%b wr=%0d required 14 1 1 0 1 8",
               ALUOutE, stallsigE, hazardBrs, hazardArs, MRE, WriteRegE);
    end
    clr();
    stallE = 1; ALUControlE = 5'd0; SrcAE = 1; SrcBE = 2;
    RegWriteE = 1; RegDstE = 1; RdE = 9;
    step();
    checks++;
    if (RWE !== 1'b0 || ALUOutE !== 0 || stallsigE !== 1'b0 ||
        hazardBrs !== 1'b1) begin
      errors++;
      $display("FAIL lw_bubble: rwe=%b alu=%h stall=%b hBrs=%b required 0 0 0 1",
               RWE, ALUOutE, stallsigE, hazardBrs);
    end
    clr();
    ALUControlE = 5'd0; forwardBrs = 1; MemDataEf = 32'h100;
    SrcAE = 1; SrcBE = 2; RegWriteE = 1; RegDstE = 1; RdE = 9;
    step();
    checks++;
    if (ALUOutE !== 32'h102 || hazardBrs !== 1'b0) begin
      errors++;
      $display("FAIL lw_consume: alu=%h hBrs=%b required 102 0",
               ALUOutE, hazardBrs);
    end
  endtask

  task automatic test_hazard_filter();
    // lw in decode: rt is its destination, not a source
    clr();
    ALUControlE = 5'd0; RegWriteE = 1; RegDstE = 1; RdE = 6;
    NextRs = 1; NextRt = 6; Nextop = 6'h23;
    step();
    checks++;
    if ({hazardArs, hazardArt} !== 2'b00) begin
      errors++;
      $display("FAIL hz_lw_rt: flags=%b required 00", {hazardArs, hazardArt});
    end
    // sw in decode reads both rs and rt
    NextRs = 6; Nextop = 6'h2B;
    step();
    checks++;
    if ({hazardArs, hazardArt} !== 2'b11) begin
      errors++;
      $display("FAIL hz_sw_both: flags=%b required 11", {hazardArs, hazardArt});
    end
    // j in decode has no register sources
    Nextop = 6'd2;
    step();
    checks++;
    if ({hazardArs, hazardArt} !== 2'b00) begin
      errors++;
      $display("FAIL hz_jump: flags=%b required 00", {hazardArs, hazardArt});
    end
    // writes to $0 never create a dependency
    RdE = 0; NextRs = 0; NextRt = 0; Nextop = 6'd0;
    step();
    checks++;
    if ({hazardArs, hazardArt} !== 2'b00) begin
      errors++;
      $display("FAIL hz_zero: flags=%b required 00", {hazardArs, hazardArt});
    end
    // load rt-only match still stalls
    clr();
    ALUControlE = 5'd20; RegWriteE = 1; MemtoRegE = 1; RtE = 12;
    NextRs = 1; NextRt = 12; Nextop = 6'd4;
    step();
    checks++;
    if ({stallsigE, hazardBrs, hazardBrt} !== 3'b101) begin
      errors++;
      $display("FAIL hz_load_rt: flags=%b required 101",
               {stallsigE, hazardBrs, hazardBrt});
    end
    // flush clears the pending stall and flags
    clr();
    ALUflush = 1;
    step();
    checks++;
    if ({stallsigE, hazardBrs, hazardBrt} !== 3'b000) begin
      errors++;
      $display("FAIL hz_flush: flags=%b required 000",
               {stallsigE, hazardBrs, hazardBrt});
    end
  endtask

  task automatic test_branch();
    clr();
    ALUControlE = 5'd22; SrcAE = 9; SrcBE = 9; PCE = 20;
    SignImmE = 32'hFFFF_FFFD;
    step();
    checks++;
    if (BranchE !== 1'b1 || targetaddE !== 32'd18) begin
      errors++;
      $display("FAIL beq_taken: br=%b tgt=%0d required 1 18",
               BranchE, targetaddE);
    end
    clr();
    ALUflush = 1; ALUControlE = 5'd0; SrcAE = 3; SrcBE = 4;
    RegWriteE = 1; RegDstE = 1; RdE = 5;
    step();
    checks++;
    if (BranchE !== 1'b0 || RWE !== 1'b0 || ALUOutE !== 0 ||
        WriteRegE !== 0) begin
      errors++;
      $display("FAIL beq_flush: br=%b rwe=%b alu=%h wr=%0d required 0 0 0 0",
               BranchE, RWE, ALUOutE, WriteRegE);
    end
    clr();
    ALUControlE = 5'd22; SrcAE = 9; SrcBE = 8; PCE = 20;
    step();
    checks++;
    if (BranchE !== 1'b0) begin
      errors++;
      $display("FAIL beq_not: br=%b required 0", BranchE);
    end
    ALUControlE = 5'd23; SignImmE = 5;
    step();
    checks++;
    if (BranchE !== 1'b1 || targetaddE !== 32'd26) begin
      errors++;
      $display("FAIL bne_taken: br=%b tgt=%0d required 1 26",
               BranchE, targetaddE);
    end
  endtask

  task automatic test_jump();
    clr();
    ALUControlE = 5'd25; PCE = 40; jumpaddM = 100; RegWriteE = 1;
    RtE = 2; RdE = 3;
    step();
    checks++;
    if (targetaddE !== 32'd100 || ALUOutE !== 32'd41 ||
        WriteRegE !== 5'd31 || BranchE !== 1'b1) begin
      errors++;
      $display("FAIL jal: tgt=%0d alu=%0d wr=%0d br=%b required 100 41 31 1",
               targetaddE, ALUOutE, WriteRegE, BranchE);
    end
    clr();
    ALUControlE = 5'd26; SrcAE = 32'h55;
    step();
    checks++;
    if (targetaddE !== 32'h55 || BranchE !== 1'b1) begin
      errors++;
      $display("FAIL jr: tgt=%h br=%b required 55 1", targetaddE, BranchE);
    end
  endtask

  task automatic test_shift_logic();
    logic [4:0]  ops [7];
    logic [31:0] a   [7];
    logic [31:0] b   [7];
    logic [31:0] exp [7];
    ops[0] = 5'd11; a[0] = 0;             b[0] = 32'h8000_0000; exp[0] = 32'hF800_0000;
    ops[1] = 5'd8;  a[1] = 32'hFFFF_FFFF; b[1] = 1;             exp[1] = 1;
    ops[2] = 5'd18; a[2] = 32'hFFFF_0000; b[2] = 0;             exp[2] = 32'hFFFF_00FF;
    ops[3] = 5'd12; a[3] = 32'h24;        b[3] = 1;             exp[3] = 32'd16;
    ops[4] = 5'd7;  a[4] = 0;             b[4] = 0;             exp[4] = 32'hFFFF_FFFF;
    ops[5] = 5'd2;  a[5] = 3;             b[5] = 5;             exp[5] = 32'hFFFF_FFFE;
    ops[6] = 5'd29; a[6] = 3;             b[6] = 5;             exp[6] = 0;
    for (int i = 0; i < 7; i++) begin
      clr();
      ALUControlE = ops[i]; SrcAE = a[i]; SrcBE = b[i];
      shmntE = 4; uSignImmE = 32'h0000_00FF;
      step();
      checks++;
      if (ALUOutE !== exp[i] || WriteDataE !== b[i]) begin
        errors++;
        $display("FAIL alu_op%0d: alu=%h wd=%h required %h %h",
                 ops[i], ALUOutE, WriteDataE, exp[i], b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clr();
    ALUControlE = 5'd15; SrcAE = 100; SignImmE = 32'hFFFF_FFF6;
    RegWriteE = 1; RtE = 7; NextRs = 7; Nextop = 6'h08;
    step();
    checks++;
    if (ALUOutE !== 32'd90 || hazardArs !== 1'b1 || WriteRegE !== 5'd7) begin
      errors++;
      $display("FAIL b2b_addi: alu=%0d hArs=%b wr=%0d required 90 1 7",
               ALUOutE, hazardArs, WriteRegE);
    end
    clr();
    ALUControlE = 5'd21; MemWriteE = 1; forwardArs = 1; ALUOutEf = 90;
    forwardCrt = 1; MforwardE = 32'hCAFE; SignImmE = 2;
    step();
    checks++;
    if (ALUOutE !== 32'd92 || WriteDataE !== 32'hCAFE || MWE !== 1'b1 ||
        RWE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sw: alu=%0d wd=%h mwe=%b rwe=%b required 92 cafe 1 0",
               ALUOutE, WriteDataE, MWE, RWE);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_add_forward();
    test_load_stall();
    test_hazard_filter();
    test_branch();
    test_jump();
    test_shift_logic();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_ex_stage.md
# mips_ex_stage

Execute stage of the five-stage MIPS pipeline, between the register-file/decode stage and main memory. It holds the ID/EX→EX/MEM pipeline register, resolves operand forwarding and performs the ALU operation. It also resolves branches and jumps and detects the data hazards of the instruction currently being decoded. Its flush/stall outputs steer the PC, the instruction RAM and the decode stage.

## Interface
Parameters: none.
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- stallE  in  1  stall pulse (wired from stallsigE)
- ALUflush  in  1  flush (wired from BranchE)
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  decoded control
- ALUControlE  in  5  operation code (see Operation)
- ALUSrcE  in  1  0: operand B = rt data, 1: SignImmE
- RegDstE  in  1  0: dest = RtE, 1: dest = RdE
- SrcAE, SrcBE  in  32  rs / rt register data
- RtE, RdE  in  5  register addresses
- SignImmE, uSignImmE  in  32  sign- / zero-extended immediate
- shmntE  in  5  shift amount
- PCE  in  32  word PC of this instruction
- jumpaddM  in  32  absolute j/jal target
- NextRs, NextRt  in  5  rs/rt of the instruction in decode
- Nextop  in  6  opcode of the instruction in decode
- forwardArs/Art  in  1  use ALUOutEf (wired from hazardArs/Art)
- ALUOutEf  in  32  previous ALU result (wired from ALUOutE)
- forwardBrs/Brt  in  1  use MemDataEf (wired from hazardBrs/Brt)
- MemDataEf  in  32  load data from memory stage
- forwardCrs/Crt  in  1  use MforwardE (from memory stage)
- MforwardE  in  32  memory-stage forward data
- RWE, MRE, MWE  out  1  registered RegWrite/MemtoReg/MemWrite
- BranchE  out  1  registered taken-branch/jump pulse
- ALUOutE  out  32  registered result / memory word address
- WriteDataE  out  32  registered store data (forwarded rt)
- WriteRegE  out  5  registered destination
- targetaddE  out  32  registered redirect target
- hazardArs/Art, hazardBrs/Brt  out  1  registered forward flags
- stallsigE  out  1  registered one-cycle stall request

## Operation
- Operand A: forwardArs ? ALUOutEf : forwardBrs ? MemDataEf : forwardCrs ? MforwardE : SrcAE. Operand R (rt) is selected the same way using the *rt flags. Operand B = ALUSrcE ? SignImmE : R.
- ALUControlE encoding:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt (signed).
  - 9 sll, 10 srl, 11 sra (by shmntE); 12 sllv, 13 srlv, 14 srav (by A[4:0], shifting R).
  - 15 addi, 16 addiu (A+SignImmE); 17 andi, 18 ori, 19 xori (with uSignImmE).
  - 20 lw, 21 sw (A+SignImmE word address).
  - 22 beq, 23 bne, 24 j, 25 jal, 26 jr.
  - 27–31 nop (result 0).
- Arithmetic is 32-bit wrap-around; no overflow trap.
- Branch control:
  - beq taken if A==R; bne taken if A!=R. Target = PCE+1+SignImmE.
  - j/jal target = jumpaddM; jr target = A.
  - jal result = PCE+1, destination 31.
- WriteRegE = RegDstE ? RdE : RtE (31 for jal). WriteDataE = R.
- Hazard detection against decode. Valid only if the EX instruction is not a bubble, RegWriteE=1 and its destination is not 0.
  - rs is compared unless Nextop ∈ {2,3}.
  - rt is compared only for Nextop ∈ {0,4,5,0x2B}.
  - Match and MemtoRegE=0: set hazardA* for the matching operand.
  - Match and MemtoRegE=1: set stallsigE and hazardB*.

## Timing
- All outputs are registered on the rising CLOCK edge. Latency is one cycle.
- RESET: all outputs are 0 at the next edge, with priority over everything else.
- ALUflush=1: register a bubble (RWE=MRE=MWE=BranchE=0, results 0) and clear all hazard flags and stallsigE. Priority is just below RESET.
- stallE=1:
  - Register a bubble.
  - stallsigE returns to 0.
  - hazardB* and hazardA* hold their values, so the stalled dependent consumes MemDataEf next cycle.
- BranchE is a single-cycle pulse. Hazard flags last exactly one instruction: they are recomputed at every non-stall edge.
- Simultaneous rs and rt matches set both flags. A load match dominates (stall) even if only one operand matches.

## Test plan
- Reset sequence: RESET=1 one cycle → all outputs 0; stallsigE=0.
- add with SrcAE=5, SrcBE=7, RegDstE=1, RdE=3 → ALUOutE=12, WriteRegE=3, RWE=1 after one edge. Decode instruction reading rs=3 → hazardArs=1. Its next add uses 12.
- lw with A=10, SignImmE=4, MemtoRegE=1, RtE=8; next op uses rs=8 → ALUOutE=14 and stallsigE=1. Next edge yields a bubble with hazardBrs kept. The dependent then uses MemDataEf.
- beq with A=R=9, PCE=20, SignImmE=-3 → BranchE=1, targetaddE=18. The following edge with ALUflush=1 outputs a bubble. With A≠R → BranchE=0.
- jal with PCE=40, jumpaddM=100 → targetaddE=100, ALUOutE=41, WriteRegE=31. jr with A=0x55 → targetaddE=0x55.
- Shifts and logic: sra with R=0x80000000, shmnt=4 → 0xF8000000. slt with -1 vs 1 → 1. ori 0xFFFF0000 | uimm 0x00FF → 0xFFFF00FF.
